// File: rtl/pwm_cap_pkg.sv
// Shared types, defaults and helpers for the PWM duty capture block.
package pwm_cap_pkg;

    localparam int DEF_NUM_CH      = 2;
    localparam int DEF_CNT_W       = 11;
    localparam int DEF_TIMEOUT_CYC = 2048;
    localparam int DEF_SYNC_STAGES = 2;

    // Widest duty word carried between channel and top; channels sign-extend into it
    localparam int DUTY_MAX_W      = 32;

    typedef struct packed {
        logic signed [DUTY_MAX_W-1:0] duty;
        logic                         vld;
        logic                         timeout;
        logic                         overlap;
    } ch_status_t;

    // Bits needed to count 0 .. max_count-1, never less than one
    function automatic int cnt_width(input int max_count);
        return ($clog2(max_count) < 1) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/pwm_ch_capture.sv
// One motor channel: input synchroniser, edge detect, saturating high-time
// counters, idle timeout and sticky forward/reverse overlap flag.
module pwm_ch_capture
    import pwm_cap_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwm1,
    input  logic       pwm2,
    input  logic       clr_err,
    output ch_status_t status,
    output logic       any_hi
);

    localparam int                IDLE_W    = cnt_width(TIMEOUT_CYC);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [IDLE_W-1:0] IDLE_PRE  = IDLE_W'(TIMEOUT_CYC - 2);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic               p1_s;
    logic               p2_s;
    logic               p1_d;
    logic               p2_d;
    logic               rise;
    logic               fall;
    logic               idle_evt;
    logic [CNT_W-1:0]   fwd_cnt;
    logic [CNT_W-1:0]   rev_cnt;
    logic [IDLE_W-1:0]  idle_cnt;
    logic signed [CNT_W:0] duty_q;
    logic               vld_q;
    logic               timeout_q;
    logic               overlap_q;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign p1_s = pwm1;
        assign p2_s = pwm2;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] s1;
        logic [SYNC_STAGES-1:0] s2;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1 <= '0;
                s2 <= '0;
            end else begin
                s1[0] <= pwm1;
                s2[0] <= pwm2;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    s1[i] <= s1[i-1];
                    s2[i] <= s2[i-1];
                end
            end
        end

        assign p1_s = s1[SYNC_STAGES-1];
        assign p2_s = s2[SYNC_STAGES-1];
    end

    assign rise     = (p1_s & ~p1_d) | (p2_s & ~p2_d);
    assign fall     = (~p1_s & p1_d) | (~p2_s & p2_d);
    // Fires only on the transition into the saturated idle value
    assign idle_evt = (idle_cnt == IDLE_PRE) & ~rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_d    <= 1'b0;
            p2_d    <= 1'b0;
            fwd_cnt <= '0;
            rev_cnt <= '0;
        end else begin
            p1_d <= p1_s;
            p2_d <= p2_s;
            if (rise) begin
                fwd_cnt <= CNT_W'(p1_s);
                rev_cnt <= CNT_W'(p2_s);
            end else begin
                if (p1_s && (fwd_cnt != CNT_MAX))
                    fwd_cnt <= fwd_cnt + CNT_W'(1);
                if (p2_s && (rev_cnt != CNT_MAX))
                    rev_cnt <= rev_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (rise) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_LAST) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    // A fall capture takes priority over the idle timeout zeroing the duty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q    <= '0;
            vld_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            vld_q <= fall | idle_evt;
            if (fall)
                duty_q <= {1'b0, fwd_cnt} - {1'b0, rev_cnt};
            else if (idle_evt)
                duty_q <= '0;
            if (rise)
                timeout_q <= 1'b0;
            else if (idle_evt)
                timeout_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overlap_q <= 1'b0;
        else if (p1_s && p2_s)
            overlap_q <= 1'b1;
        else if (clr_err)
            overlap_q <= 1'b0;
    end

    always_comb begin
        status         = '0;
        status.duty    = DUTY_MAX_W'(duty_q);
        status.vld     = vld_q;
        status.timeout = timeout_q;
        status.overlap = overlap_q;
    end

    assign any_hi = p1_s | p2_s;

endmodule

// File: rtl/pwm_duty_capture.sv
// Signed PWM duty capture for NUM_CH forward/reverse channel pairs, with a
// frame strobe on the last falling PWM or on frame timeout.
module pwm_duty_capture
    import pwm_cap_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           PWM1,
    input  logic [NUM_CH-1:0]           PWM2,
    input  logic                        clr_err,
    output logic [NUM_CH*(CNT_W+1)-1:0] duty,
    output logic [NUM_CH-1:0]           duty_vld,
    output logic [NUM_CH-1:0]           ch_timeout,
    output logic [NUM_CH-1:0]           overlap_err,
    output logic                        frame_vld,
    output logic                        frame_timeout
);

    localparam int               DW       = CNT_W + 1;
    localparam int               FRM_W    = cnt_width(TIMEOUT_CYC);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(TIMEOUT_CYC - 1);
    localparam logic [FRM_W-1:0] FRM_PRE  = FRM_W'(TIMEOUT_CYC - 2);

    ch_status_t        ch_st [NUM_CH];
    logic [NUM_CH-1:0] ch_hi;
    logic              any_hi;
    logic              any_hi_d;
    logic              last_fall;
    logic              frame_evt;
    logic [FRM_W-1:0]  frame_cnt;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_ch_capture #(
            .CNT_W       (CNT_W),
            .TIMEOUT_CYC (TIMEOUT_CYC),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .pwm1    (PWM1[g]),
            .pwm2    (PWM2[g]),
            .clr_err (clr_err),
            .status  (ch_st[g]),
            .any_hi  (ch_hi[g])
        );
    end

    always_comb begin
        duty        = '0;
        duty_vld    = '0;
        ch_timeout  = '0;
        overlap_err = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            duty[i*DW +: DW] = DW'(ch_st[i].duty);
            duty_vld[i]      = ch_st[i].vld;
            ch_timeout[i]    = ch_st[i].timeout;
            overlap_err[i]   = ch_st[i].overlap;
        end
    end

    assign any_hi    = |ch_hi;
    assign last_fall = ~any_hi & any_hi_d;
    // Suppressed while a strobe is out so the clearing counter cannot re-trigger
    assign frame_evt = (frame_cnt == FRM_PRE) & ~frame_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_hi_d      <= 1'b0;
            frame_vld     <= 1'b0;
            frame_timeout <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            any_hi_d      <= any_hi;
            frame_vld     <= last_fall | frame_evt;
            frame_timeout <= frame_evt & ~last_fall;
            if (frame_vld)
                frame_cnt <= '0;
            else if (frame_cnt != FRM_LAST)
                frame_cnt <= frame_cnt + FRM_W'(1);
        end
    end

endmodule
